// File: rtl/audio_param_framer.sv
// audio_param_framer: packs sound samples and flight parameters into alternating packet-buffer banks
// Optional FRAMER_CSUM_EN appends a mod-2^32 sum word after the parameter words.
module audio_param_framer #(
  parameter int NCH        = 2,
  parameter int SAMPLES    = 500,
  parameter int PARAMS     = 12,
  parameter int PARAM_WRAP = 48,
  parameter int BANK_AW    = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                timer,
  input  logic                msec,
  output logic [8:0]          snd_rd,
  input  logic [16*NCH-1:0]   snd_data,
  output logic [7:0]          prm_rd,
  input  logic [31:0]         prm_data,
  output logic                wr_en,
  output logic [BANK_AW:0]    wr_addr,
  output logic [31:0]         wr_data,
  output logic                tx_req,
  output logic                tx_bank,
  input  logic                tx_ack,
  output logic                frame_rdy,
  output logic [3:0]          frame_cnt,
  output logic [7:0]          ovr_cnt
);
`ifdef FRAMER_CSUM_EN
  typedef enum logic [2:0] {IDLE, WAIT_TICK, SOUND, PARAM, CSUM, DONE} state_t;
  logic [31:0] sum_q;
`else
  typedef enum logic [2:0] {IDLE, WAIT_TICK, SOUND, PARAM, DONE} state_t;
`endif
  state_t             state_q;
  logic               msec_q;
  logic               tick;
  logic               dv_q;
  logic               dsrc_q;
  logic               wr_bank_q;
  logic [7:0]         pcnt_q;
  logic [BANK_AW-1:0] widx_q;
  logic [31:0]        snd_word;
  logic [31:0]        word;
  if (NCH == 2) begin : g_w
    assign snd_word = snd_data;
  end else begin : g_w
    assign snd_word = {16'h0, snd_data[15:0]};
  end
  assign tick = msec & ~msec_q;
  assign word = dsrc_q ? prm_data : snd_word;
  // Frame sequencer: issues reads, writes returned data one cycle later, hands banks to the transmitter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      msec_q    <= 1'b0;
      dv_q      <= 1'b0;
      dsrc_q    <= 1'b0;
      wr_bank_q <= 1'b0;
      pcnt_q    <= '0;
      widx_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      tx_req    <= 1'b0;
      tx_bank   <= 1'b0;
      frame_rdy <= 1'b0;
      snd_rd    <= '0;
      prm_rd    <= '0;
      frame_cnt <= '0;
      ovr_cnt   <= '0;
`ifdef FRAMER_CSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      msec_q    <= msec;
      frame_rdy <= 1'b0;
      wr_en     <= dv_q;
      dv_q      <= 1'b0;
      if (dv_q) begin
        wr_data <= word;
        wr_addr <= {wr_bank_q, widx_q};
        widx_q  <= widx_q + BANK_AW'(1);
`ifdef FRAMER_CSUM_EN
        sum_q   <= sum_q + word;
`endif
      end
      if (tick && state_q != WAIT_TICK) ovr_cnt <= ovr_cnt + 8'(ovr_cnt != 8'hFF);
      if (tx_req && tx_ack) tx_req <= 1'b0;
      case (state_q)
        IDLE: if (timer) state_q <= WAIT_TICK;
        WAIT_TICK: if (tick) begin
          frame_cnt <= frame_cnt + 4'd1;
          snd_rd    <= '0;
          pcnt_q    <= '0;
          widx_q    <= '0;
`ifdef FRAMER_CSUM_EN
          sum_q     <= '0;
`endif
          state_q   <= SOUND;
        end
        SOUND: begin
          dv_q   <= 1'b1;
          dsrc_q <= 1'b0;
          if (snd_rd == 9'(SAMPLES - 1)) state_q <= PARAM;
          else snd_rd <= snd_rd + 9'd1;
        end
        PARAM: if (pcnt_q != 8'(PARAMS)) begin
          dv_q   <= 1'b1;
          dsrc_q <= 1'b1;
          pcnt_q <= pcnt_q + 8'd1;
          prm_rd <= (prm_rd == 8'(PARAM_WRAP - 1)) ? 8'd0 : prm_rd + 8'd1;
        end else if (!dv_q) begin
`ifdef FRAMER_CSUM_EN
          state_q <= CSUM;
`else
          state_q <= DONE;
`endif
        end
`ifdef FRAMER_CSUM_EN
        CSUM: begin
          wr_en   <= 1'b1;
          wr_data <= sum_q;
          wr_addr <= {wr_bank_q, widx_q};
          state_q <= DONE;
        end
`endif
        DONE: if (!tx_req || tx_ack) begin
          tx_req    <= 1'b1;
          tx_bank   <= wr_bank_q;
          wr_bank_q <= ~wr_bank_q;
          frame_rdy <= 1'b1;
          state_q   <= WAIT_TICK;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_param_framer.sv
// tb_audio_param_framer: scoreboard bench for audio_param_framer (honours FRAMER_CSUM_EN)
module tb_audio_param_framer;
  localparam int S = 4, P = 2, WRAP = 5, AW = 4;
`ifdef FRAMER_CSUM_EN
  localparam int LAT = S + P + 4;
`else
  localparam int LAT = S + P + 3;
`endif
  logic clock = 0, reset, timer, msec, tx_ack;
  logic [8:0] snd_rd;
  logic [31:0] snd_data, prm_data, wr_data;
  logic [7:0] prm_rd, ovr_cnt;
  logic wr_en, tx_req, tx_bank, frame_rdy;
  logic [AW:0] wr_addr;
  logic [3:0] frame_cnt;
  int checks = 0, errors = 0;
  int bank = 0, last_bank = 0, pptr = 0, n, saw;
  logic ones = 0;
  logic [63:0] exp_q[$];

  audio_param_framer #(.NCH(2), .SAMPLES(S), .PARAMS(P), .PARAM_WRAP(WRAP), .BANK_AW(AW)) dut (
    .clock(clock), .reset(reset), .timer(timer), .msec(msec),
    .snd_rd(snd_rd), .snd_data(snd_data), .prm_rd(prm_rd), .prm_data(prm_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .tx_req(tx_req), .tx_bank(tx_bank), .tx_ack(tx_ack),
    .frame_rdy(frame_rdy), .frame_cnt(frame_cnt), .ovr_cnt(ovr_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    snd_data <= ones ? 32'hFFFF_FFFF : {7'd0, snd_rd, 7'd0, snd_rd};
    prm_data <= ones ? 32'hFFFF_FFFF : (32'hC0DE_0000 | {24'd0, prm_rd});
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clock) if (wr_en && !reset) begin
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write: addr %h data %h", wr_addr, wr_data);
    end else chk("write", {27'd0, wr_addr, wr_data}, exp_q.pop_front());
  end

  task automatic push_frame();
    logic [31:0] w;
    int p;
`ifdef FRAMER_CSUM_EN
    logic [31:0] s;
    s = 0;
`endif
    p = pptr;
    for (int k = 0; k < S + P; k++) begin
      if (k < S) w = ones ? 32'hFFFF_FFFF : {k[15:0], k[15:0]};
      else begin
        w = ones ? 32'hFFFF_FFFF : (32'hC0DE_0000 | 32'(p));
        p = (p == WRAP - 1) ? 0 : p + 1;
      end
`ifdef FRAMER_CSUM_EN
      s += w;
`endif
      exp_q.push_back({32'((bank << AW) + k), w});
    end
`ifdef FRAMER_CSUM_EN
    exp_q.push_back({32'((bank << AW) + S + P), s});
`endif
    pptr = p;
    last_bank = bank;
    bank ^= 1;
  endtask

  task automatic frame(input int hold, input int retick);
    push_frame();
    @(negedge clock) msec = 1;
    @(posedge clock);
    n = 0;
    do begin
      @(posedge clock);
      n++;
      #1 msec = (n < hold) || (n == retick);
    end while (!frame_rdy && n < 60);
    chk("latency", n, LAT);
  endtask

  task automatic pulse_msec();
    @(negedge clock) msec = 1;
    @(negedge clock) msec = 0;
  endtask

  task automatic ack();
    @(negedge clock) tx_ack = 1;
    @(negedge clock) tx_ack = 0;
  endtask

  task automatic check_zero();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_bank", tx_bank, 0);
    chk("rst_frame_rdy", frame_rdy, 0);
    chk("rst_snd_rd", snd_rd, 0);
    chk("rst_prm_rd", prm_rd, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_ovr_cnt", ovr_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1; timer = 0; msec = 0; tx_ack = 0;
    repeat (3) @(negedge clock);
    check_zero();
    reset = 0;
    ack();
    chk("ack_ignored", tx_req, 0);
    @(negedge clock) timer = 1;
    frame(100, 0);
    chk("f1_tx_req", tx_req, 1);
    chk("f1_tx_bank", tx_bank, 0);
    chk("f1_frame_cnt", frame_cnt, 1);
    chk("f1_prm_rd", prm_rd, 2);
    @(posedge clock); #1;
    chk("rdy_pulse", frame_rdy, 0);
    repeat (4) @(posedge clock);
    #1 chk("held_msec_one_tick", frame_cnt, 1);
    msec = 0;
    timer = 0;
    ack();
    chk("ack_clears", tx_req, 0);
    for (int i = 2; i <= 5; i++) begin
      frame(1, 0);
      chk("multi_tx_bank", tx_bank, last_bank);
      chk("multi_tx_req", tx_req, 1);
      ack();
    end
    chk("multi_frame_cnt", frame_cnt, 5);
    chk("multi_prm_rd", prm_rd, 32'(pptr));
    frame(1, 2);
    chk("ovr_mid_sound", ovr_cnt, 1);
    chk("ovr_frame_cnt", frame_cnt, 6);
    chk("ovr_tx_bank", tx_bank, 1);
    ack();
    frame(1, 0);
    chk("stall_a_bank", tx_bank, 0);
    push_frame();
    pulse_msec();
    saw = 0;
    repeat (20) begin
      @(posedge clock);
      #1 if (frame_rdy) saw = 1;
    end
    chk("stall_no_rdy", saw, 0);
    chk("stall_tx_req", tx_req, 1);
    chk("stall_tx_bank", tx_bank, 0);
    chk("stall_frame_cnt", frame_cnt, 8);
    pulse_msec();
    repeat (2) @(negedge clock);
    chk("stall_drop_ovr", ovr_cnt, 2);
    chk("stall_drop_fc", frame_cnt, 8);
    @(negedge clock) tx_ack = 1;
    @(posedge clock);
    #1;
    chk("handover_rdy", frame_rdy, 1);
    chk("handover_req", tx_req, 1);
    chk("handover_bank", tx_bank, 1);
    @(negedge clock) tx_ack = 0;
    ack();
    chk("handover_ack_clears", tx_req, 0);
    ones = 1;
    frame(1, 0);
    ones = 0;
    chk("ones_bank", tx_bank, 0);
    ack();
    push_frame();
    @(negedge clock) msec = 1;
    @(posedge clock);
    repeat (4) @(posedge clock);
    #1 reset = 1;
    exp_q.delete();
    bank = 0; pptr = 0; msec = 0; timer = 0;
    @(negedge clock);
    check_zero();
    @(negedge clock) reset = 0;
    pulse_msec();
    repeat (15) @(negedge clock);
    chk("no_timer_frame_cnt", frame_cnt, 0);
    chk("no_timer_tx_req", tx_req, 0);
    timer = 1;
    frame(1, 0);
    chk("post_rst_bank", tx_bank, 0);
    chk("post_rst_fc", frame_cnt, 1);
    chk("post_rst_prm_rd", prm_rd, 2);
    repeat (3) @(negedge clock);
    chk("pending_writes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
